// File: rtl/crc_frame_tx_if.sv
// Byte-stream transmitter interface: parallel payload load side plus the
// valid/ready byte stream and frame status. The transmitter uses the slave modport.
interface crc_frame_tx_if #(
    parameter int PAYLOAD_BYTES = 8
);
    logic                       dataEn;
    logic [8*PAYLOAD_BYTES-1:0] dataIn;
    logic                       busy;
    logic                       overrun;
    logic [7:0]                 byteOut;
    logic                       byteValid;
    logic                       byteReady;
    logic                       frameDone;
    logic [15:0]                crcOut;

    modport master (
        output dataEn,
        output dataIn,
        output byteReady,
        input  busy,
        input  overrun,
        input  byteOut,
        input  byteValid,
        input  frameDone,
        input  crcOut
    );

    modport slave (
        input  dataEn,
        input  dataIn,
        input  byteReady,
        output busy,
        output overrun,
        output byteOut,
        output byteValid,
        output frameDone,
        output crcOut
    );
endinterface

// File: rtl/crc_frame_tx.sv
// CRC-framed byte transmitter: sends one payload word MSB byte first, then the
// CRC-16/CCITT-FALSE of the payload (high byte first), then holds off for a gap.
module crc_frame_tx #(
    parameter int          PAYLOAD_BYTES = 8,
    parameter int          IDLE_GAP      = 2,
    parameter logic [15:0] CRC_INIT      = 16'hFFFF
) (
    input logic           clk,
    input logic           rst,
    crc_frame_tx_if.slave link
);

    localparam int DATA_W = 8 * PAYLOAD_BYTES;
    localparam int CNT_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int GAP_W  = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IDLE_GAP);

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        CRC_HI,
        CRC_LO,
        GAP
    } TxState;

    TxState            state;
    logic [DATA_W-1:0] shiftReg;
    logic [DATA_W-1:0] shiftNext;
    logic [CNT_W-1:0]  byteCnt;
    logic [GAP_W-1:0]  gapCnt;
    logic [15:0]       crc;
    logic [15:0]       crcNext;
    logic              handshake;

    // One byte of CRC-16 0x1021, MSB first, non-reflected.
    function automatic logic [15:0] crcStep(input logic [15:0] crcIn, input logic [7:0] data);
        logic [15:0] c;
        logic        fb;
        c = crcIn;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    assign handshake = link.byteValid && link.byteReady;
    assign shiftNext = shiftReg << 8;
    assign crcNext   = crcStep(crc, shiftReg[DATA_W-1 -: 8]);
    assign link.busy = (state != IDLE);

    // byteOut always carries the byte on offer; it only changes on a handshake,
    // so a stalled sink sees stable data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            shiftReg       <= '0;
            byteCnt        <= '0;
            gapCnt         <= '0;
            crc            <= CRC_INIT;
            link.byteOut   <= 8'h00;
            link.byteValid <= 1'b0;
            link.overrun   <= 1'b0;
            link.frameDone <= 1'b0;
            link.crcOut    <= 16'h0000;
        end else begin
            link.overrun   <= link.dataEn && (state != IDLE);
            link.frameDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (link.dataEn) begin
                        shiftReg       <= link.dataIn;
                        byteCnt        <= '0;
                        crc            <= CRC_INIT;
                        link.byteOut   <= link.dataIn[DATA_W-1 -: 8];
                        link.byteValid <= 1'b1;
                        state          <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (handshake) begin
                        crc      <= crcNext;
                        shiftReg <= shiftNext;
                        if (byteCnt == LAST_BYTE) begin
                            link.byteOut <= crcNext[15:8];
                            state        <= CRC_HI;
                        end else begin
                            byteCnt      <= byteCnt + 1'b1;
                            link.byteOut <= shiftNext[DATA_W-1 -: 8];
                        end
                    end
                end
                CRC_HI: begin
                    if (handshake) begin
                        link.byteOut <= crc[7:0];
                        state        <= CRC_LO;
                    end
                end
                CRC_LO: begin
                    if (handshake) begin
                        link.byteValid <= 1'b0;
                        link.byteOut   <= 8'h00;
                        link.frameDone <= 1'b1;
                        link.crcOut    <= crc;
                        gapCnt         <= '0;
                        state          <= (IDLE_GAP == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    // The frameDone cycle is gap cycle zero, so busy stays
                    // high for IDLE_GAP further cycles.
                    if (gapCnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed bench for crc_frame_tx: a 9-byte instance for the CRC check string
// and a default 8-byte instance for stalls, overrun, gap and reset cases.
module tb_crc_frame_tx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    crc_frame_tx_if #(.PAYLOAD_BYTES(8)) if8 ();
    crc_frame_tx_if #(.PAYLOAD_BYTES(9)) if9 ();

    crc_frame_tx #(.PAYLOAD_BYTES(8), .IDLE_GAP(2), .CRC_INIT(16'hFFFF)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .link (if8.slave)
    );

    crc_frame_tx #(.PAYLOAD_BYTES(9), .IDLE_GAP(2), .CRC_INIT(16'hFFFF)) dut9 (
        .clk  (clk),
        .rst  (rst),
        .link (if9.slave)
    );

    int         compared   = 0;
    int         mismatched = 0;
    int         fd8        = 0;
    int         fd9        = 0;
    logic [7:0] q8[$];
    logic [7:0] q9[$];
    logic       prevStall  = 1'b0;
    logic [7:0] prevByte   = 8'h00;
    logic [7:0] exp9[11]   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                               8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] modelCrc(input logic [63:0] word);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 63; i >= 0; i--) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [63:0] word);
        if8.dataIn = word;
        if8.dataEn = 1'b1;
        tick();
        if8.dataEn = 1'b0;
    endtask

    task automatic waitFrameDone8(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (if8.frameDone) seen = 1'b1;
        end
        checkOutput(tag, 72'(seen), 72'd1);
    endtask

    task automatic waitIdle8(input string tag);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!if8.busy) break;
        end
        checkOutput(tag, 72'(if8.busy), 72'd0);
    endtask

    task automatic checkFrame(input string tag, input logic [63:0] word);
        logic [15:0] expCrc;
        logic [7:0]  expByte;
        expCrc = modelCrc(word);
        checkOutput({tag, "Len"}, 72'(q8.size()), 72'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < 8)       expByte = word[63 - 8*i -: 8];
            else if (i == 8) expByte = expCrc[15:8];
            else             expByte = expCrc[7:0];
            if (i < q8.size()) checkOutput({tag, "Byte"}, 72'(q8[i]), 72'(expByte));
        end
        checkOutput({tag, "Crc"}, 72'(if8.crcOut), 72'(expCrc));
    endtask

    // Stream monitor: collects accepted bytes, counts frameDone pulses and
    // checks that a stalled byte is still on offer one cycle later.
    always @(negedge clk) begin
        if (prevStall) begin
            checkOutput("stallByte", 72'(if8.byteOut), 72'(prevByte));
            checkOutput("stallValid", 72'(if8.byteValid), 72'd1);
        end
        prevStall <= !rst && if8.byteValid && !if8.byteReady;
        prevByte  <= if8.byteOut;
        if (!rst && if8.byteValid && if8.byteReady) q8.push_back(if8.byteOut);
        if (!rst && if9.byteValid && if9.byteReady) q9.push_back(if9.byteOut);
        if (if8.frameDone) fd8 <= fd8 + 1;
        if (if9.frameDone) fd9 <= fd9 + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] wordA;
        logic [63:0] wordB;
        int          fdBefore;
        bit          done;

        rst           = 1'b1;
        if8.dataEn    = 1'b0;
        if8.dataIn    = '0;
        if8.byteReady = 1'b1;
        if9.dataEn    = 1'b0;
        if9.dataIn    = '0;
        if9.byteReady = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("rstValid", 72'(if8.byteValid), 72'd0);
        checkOutput("rstBusy", 72'(if8.busy), 72'd0);
        checkOutput("rstByte", 72'(if8.byteOut), 72'd0);
        checkOutput("rstCrc", 72'(if8.crcOut), 72'd0);
        checkOutput("rstFlags", 72'({if8.overrun, if8.frameDone}), 72'd0);
        checkOutput("rstBusy9", 72'(if9.busy), 72'd0);
        tick();
        rst = 1'b0;

        $display("[TB] test 1: CRC check string on 9-byte instance");
        if9.dataIn = 72'h313233343536373839;
        if9.dataEn = 1'b1;
        tick();
        if9.dataEn = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            checkOutput("t1Valid", 72'(if9.byteValid), 72'd1);
            checkOutput("t1Byte", 72'(if9.byteOut), 72'(exp9[k]));
        end
        @(negedge clk);
        checkOutput("t1ValidDrop", 72'(if9.byteValid), 72'd0);
        checkOutput("t1FrameDone", 72'(if9.frameDone), 72'd1);
        checkOutput("t1CrcOut", 72'(if9.crcOut), 72'h29B1);
        @(negedge clk);
        checkOutput("t1DonePulse", 72'(if9.frameDone), 72'd0);
        checkOutput("t1Count", 72'(q9.size()), 72'd11);

        $display("[TB] test 2: toggling byteReady");
        wordA = 64'h0123456789ABCDEF;
        q8.delete();
        applyStimulus(wordA);
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            if8.byteReady = ~if8.byteReady;
            @(negedge clk);
            if (if8.frameDone) done = 1'b1;
            if (!done) tick();
        end
        checkOutput("t2Done", 72'(done), 72'd1);
        if8.byteReady = 1'b1;
        checkFrame("t2", wordA);
        waitIdle8("t2Idle");

        $display("[TB] test 3: overrun during frame");
        wordA = 64'hA1A2A3A4A5A6A7A8;
        wordB = 64'h5555AAAA5555AAAA;
        q8.delete();
        applyStimulus(wordA);
        tick();
        tick();
        if8.dataIn = wordB;
        if8.dataEn = 1'b1;
        tick();
        if8.dataEn = 1'b0;
        @(negedge clk);
        checkOutput("t3Overrun", 72'(if8.overrun), 72'd1);
        @(negedge clk);
        checkOutput("t3OverrunPulse", 72'(if8.overrun), 72'd0);
        waitFrameDone8("t3Done");
        checkFrame("t3", wordA);
        repeat (12) @(negedge clk);
        checkOutput("t3NoSecond", 72'(q8.size()), 72'd10);
        checkOutput("t3Idle", 72'(if8.busy), 72'd0);

        $display("[TB] test 4: idle gap with dataEn held");
        wordA = 64'h0F1E2D3C4B5A6978;
        if8.dataIn = wordA;
        if8.dataEn = 1'b1;
        waitFrameDone8("t4Done1");
        @(negedge clk);
        checkOutput("t4BusyGap1", 72'(if8.busy), 72'd1);
        @(negedge clk);
        checkOutput("t4BusyGap2", 72'(if8.busy), 72'd1);
        @(negedge clk);
        checkOutput("t4IdleSlot", 72'(if8.busy), 72'd0);
        @(negedge clk);
        checkOutput("t4Reload", 72'(if8.busy), 72'd1);
        checkOutput("t4ReloadValid", 72'(if8.byteValid), 72'd1);
        checkOutput("t4ReloadByte", 72'(if8.byteOut), 72'h0F);
        if8.dataEn = 1'b0;
        waitFrameDone8("t4Done2");
        checkOutput("t4Crc", 72'(if8.crcOut), 72'(modelCrc(wordA)));
        waitIdle8("t4Idle");

        $display("[TB] test 5: reset mid-frame");
        wordA = 64'hDEADBEEFCAFEF00D;
        applyStimulus(wordA);
        tick();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5FourthByte", 72'(if8.byteOut), 72'hEF);
        fdBefore = fd8;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5Valid", 72'(if8.byteValid), 72'd0);
        checkOutput("t5Busy", 72'(if8.busy), 72'd0);
        checkOutput("t5CrcOut", 72'(if8.crcOut), 72'd0);
        checkOutput("t5Byte", 72'(if8.byteOut), 72'd0);
        repeat (5) @(negedge clk);
        checkOutput("t5NoDone", 72'(fd8), 72'(fdBefore));
        wordB = 64'h1122334455667788;
        q8.delete();
        applyStimulus(wordB);
        waitFrameDone8("t5Done");
        checkFrame("t5", wordB);
        waitIdle8("t5Idle");

        $display("[TB] test 6: long stall after load");
        wordA = 64'h8877665544332211;
        if8.byteReady = 1'b0;
        q8.delete();
        applyStimulus(wordA);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput("t6Valid", 72'(if8.byteValid), 72'd1);
            checkOutput("t6Byte", 72'(if8.byteOut), 72'h88);
        end
        tick();
        if8.byteReady = 1'b1;
        waitFrameDone8("t6Done");
        checkFrame("t6", wordA);
        waitIdle8("t6Idle");

        checkOutput("t1DoneCount", 72'(fd9), 72'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
